// File: rtl/mem_access_stage.sv
//==============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage. Issues data-memory requests for loads and
//               stores, stalls the upstream pipe while an access is pending,
//               aborts an access after TIMEOUT cycles without acknowledge, and
//               registers the MEM/WB stage. The write-back value doubles as the
//               WB_WriteData forwarding source for EX.
//               Optional macro MEM_BYTE_LANES_EN enables byte/halfword
//               lane handling (lb/lh/lbu/lhu/sb/sh); without it every access
//               is a full word.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   // EX/MEM register contents
   input  logic [31:0] MEM_ALUOut_i,
   input  logic [31:0] MEM_RtData_i,
   input  logic [31:0] MEM_Instruction_i,
   input  logic [4:0]  MEM_DestReg_i,
   input  logic        MEM_RegWrite_i,
   input  logic        MEM_MemtoReg_i,
   input  logic        MEM_MemRead_i,
   input  logic        MEM_MemWrite_i,
   // Data-memory port
   output logic        DMem_Req_o,
   output logic        DMem_We_o,
   output logic [31:0] DMem_Addr_o,
   output logic [31:0] DMem_WData_o,
   output logic [3:0]  DMem_ByteEn_o,
   input  logic [31:0] DMem_RData_i,
   input  logic        DMem_Ack_i,
   // Pipeline control
   output logic        MEM_Stall_o,
   // MEM/WB register
   output logic [31:0] WB_WriteData_o,
   output logic [4:0]  WB_DestReg_o,
   output logic        WB_RegWrite_o,
   output logic [31:0] WB_Instruction_o,
   output logic        WB_MemErr_o
);

   // Wait counter is 8 bits wide; TIMEOUT is truncated to that width.
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;

   logic        w_mem_op;
   logic        w_is_write;
   logic        w_abort;
   logic        w_stall;
   logic [31:0] w_load_data;
   logic [31:0] w_wdata;
   logic [3:0]  w_byte_en;

   logic [31:0] wb_wdata_q,  wb_wdata_d;
   logic [4:0]  wb_dest_q,   wb_dest_d;
   logic        wb_regw_q,   wb_regw_d;
   logic [31:0] wb_instr_q,  wb_instr_d;
   logic        wb_memerr_q, wb_memerr_d;

   // A simultaneous read and write request is treated as a read.
   assign w_mem_op   = MEM_MemRead_i | MEM_MemWrite_i;
   assign w_is_write = MEM_MemWrite_i & ~MEM_MemRead_i;

   // Abort in the last permitted wait cycle; an acknowledge in that same cycle wins.
   assign w_abort = (state_q == ST_BUSY) & (cnt_q == TIMEOUT_C) & w_mem_op & ~DMem_Ack_i;

   // Stall is released in the completing (or aborting) cycle so EX/MEM and
   // MEM/WB advance together on the following edge.
   assign w_stall = w_mem_op & ~DMem_Ack_i & ~w_abort;

   // Request and stall are forced low while reset is held so a reset in the
   // middle of an access drops them immediately.
   assign DMem_Req_o  = w_mem_op & rst_ni;
   assign MEM_Stall_o = w_stall & rst_ni;
   assign DMem_We_o   = w_is_write;
   assign DMem_Addr_o = {MEM_ALUOut_i[31:2], 2'b00};

`ifdef MEM_BYTE_LANES_EN
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;

   logic [5:0]  w_opcode;
   logic [1:0]  w_lane;
   logic [7:0]  w_rbyte;
   logic [15:0] w_rhalf;

   assign w_opcode = MEM_Instruction_i[31:26];
   assign w_lane   = MEM_ALUOut_i[1:0];

   // Store lane enables and replicated write data for sub-word stores.
   always_comb begin
      w_byte_en = 4'hF;
      w_wdata   = MEM_RtData_i;
      case (w_opcode)
         OP_SB: begin
            w_byte_en = 4'b0001 << w_lane;
            w_wdata   = {4{MEM_RtData_i[7:0]}};
         end
         OP_SH: begin
            w_byte_en = 4'b0011 << {w_lane[1], 1'b0};
            w_wdata   = {2{MEM_RtData_i[15:0]}};
         end
         default: begin
            w_byte_en = 4'hF;
            w_wdata   = MEM_RtData_i;
         end
      endcase
   end

   // Load lane extraction with sign or zero extension.
   always_comb begin
      w_rbyte = DMem_RData_i[7:0];
      case (w_lane)
         2'd0:    w_rbyte = DMem_RData_i[7:0];
         2'd1:    w_rbyte = DMem_RData_i[15:8];
         2'd2:    w_rbyte = DMem_RData_i[23:16];
         default: w_rbyte = DMem_RData_i[31:24];
      endcase
      w_rhalf = w_lane[1] ? DMem_RData_i[31:16] : DMem_RData_i[15:0];
      case (w_opcode)
         OP_LB:   w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
         OP_LBU:  w_load_data = {24'h0, w_rbyte};
         OP_LH:   w_load_data = {{16{w_rhalf[15]}}, w_rhalf};
         OP_LHU:  w_load_data = {16'h0, w_rhalf};
         default: w_load_data = DMem_RData_i;
      endcase
   end
`else
   // Word-only accesses.
   assign w_byte_en   = 4'hF;
   assign w_wdata     = MEM_RtData_i;
   assign w_load_data = DMem_RData_i;
`endif

   assign DMem_ByteEn_o = w_byte_en;
   assign DMem_WData_o  = w_wdata;

   // Access FSM and wait counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_mem_op && !DMem_Ack_i) begin
                  state_q <= ST_BUSY;
                  cnt_q   <= 8'd1;
               end
            end
            ST_BUSY: begin
               if (DMem_Ack_i || !w_mem_op || w_abort) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q   <= cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= 8'd0;
            end
         endcase
      end
   end

   // MEM/WB next-state: hold while stalled, bubble with error flag on abort.
   always_comb begin
      wb_wdata_d  = wb_wdata_q;
      wb_dest_d   = wb_dest_q;
      wb_regw_d   = wb_regw_q;
      wb_instr_d  = wb_instr_q;
      wb_memerr_d = wb_memerr_q;
      if (!w_stall) begin
         if (w_abort) begin
            wb_wdata_d  = 32'h0;
            wb_dest_d   = 5'h0;
            wb_regw_d   = 1'b0;
            wb_instr_d  = 32'h0;
            wb_memerr_d = 1'b1;
         end else begin
            wb_wdata_d  = MEM_MemtoReg_i ? w_load_data : MEM_ALUOut_i;
            wb_dest_d   = MEM_DestReg_i;
            wb_regw_d   = MEM_RegWrite_i;
            wb_instr_d  = MEM_Instruction_i;
            wb_memerr_d = 1'b0;
         end
      end
   end

   // MEM/WB pipeline register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_wdata_q  <= 32'h0;
         wb_dest_q   <= 5'h0;
         wb_regw_q   <= 1'b0;
         wb_instr_q  <= 32'h0;
         wb_memerr_q <= 1'b0;
      end else begin
         wb_wdata_q  <= wb_wdata_d;
         wb_dest_q   <= wb_dest_d;
         wb_regw_q   <= wb_regw_d;
         wb_instr_q  <= wb_instr_d;
         wb_memerr_q <= wb_memerr_d;
      end
   end

   assign WB_WriteData_o   = wb_wdata_q;
   assign WB_DestReg_o     = wb_dest_q;
   assign WB_RegWrite_o    = wb_regw_q;
   assign WB_Instruction_o = wb_instr_q;
   assign WB_MemErr_o      = wb_memerr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
//==============================================================================
// Module      : tb_mem_access_stage
// Description : Scoreboard bench for mem_access_stage. The stimulus task drives
//               one instruction at a time, queues its expected MEM/WB result,
//               and checks the memory port and stall each cycle; a monitor pops
//               the queue after every non-stalled edge.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_stage;

   localparam int TIMEOUT = 16;
   localparam logic [31:0] BAD = 32'h0BAD0BAD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] alu, rt, ins, rdata;
   logic [4:0]  rd;
   logic        rw, m2r, mr, mw, ack;
   logic        req, we, stall, wb_rw, wb_err;
   logic [31:0] addr, wdata, wb_wd, wb_ins;
   logic [3:0]  be;
   logic [4:0]  wb_rd;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_ins = 32'h0;
   logic prev_ok = 1'b0;

   typedef struct {
      logic [31:0] wd;
      logic [4:0]  rd;
      logic        rw;
      logic [31:0] ins;
      logic        err;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .MEM_ALUOut_i(alu), .MEM_RtData_i(rt), .MEM_Instruction_i(ins),
      .MEM_DestReg_i(rd), .MEM_RegWrite_i(rw), .MEM_MemtoReg_i(m2r),
      .MEM_MemRead_i(mr), .MEM_MemWrite_i(mw),
      .DMem_Req_o(req), .DMem_We_o(we), .DMem_Addr_o(addr), .DMem_WData_o(wdata),
      .DMem_ByteEn_o(be), .DMem_RData_i(rdata), .DMem_Ack_i(ack),
      .MEM_Stall_o(stall),
      .WB_WriteData_o(wb_wd), .WB_DestReg_o(wb_rd), .WB_RegWrite_o(wb_rw),
      .WB_Instruction_o(wb_ins), .WB_MemErr_o(wb_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: after each edge where the stage was not stalled, MEM/WB holds a new entry.
   always @(negedge clk) begin
      exp_t e;
      if (prev_ok) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected actual=%h required=none", wb_ins);
         end else begin
            e = sb.pop_front();
            chk("wb_regwrite", {31'h0, wb_rw}, {31'h0, e.rw});
            chk("wb_instr", wb_ins, e.ins);
            chk("wb_memerr", {31'h0, wb_err}, {31'h0, e.err});
            if (!e.err) begin
               chk("wb_wdata", wb_wd, e.wd);
               chk("wb_dest", {27'h0, wb_rd}, {27'h0, e.rd});
            end
         end
      end
      prev_ok = rst_n && !stall;
   end

   // Drive one instruction (caller is just after a rising edge); ack_dly = cycles
   // before acknowledge, anything above TIMEOUT means no acknowledge at all.
   task automatic issue(input logic [31:0] i_ins, i_alu, i_rt, input logic [4:0] i_rd,
                        input logic i_rw, i_m2r, i_mr, i_mw, input int ack_dly,
                        input logic [31:0] i_rdata, exp_wb, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
      exp_t e;
      logic mop, stall_exp, done;
      int c;
      mop = i_mr | i_mw;
      ins = i_ins; alu = i_alu; rt = i_rt; rd = i_rd;
      rw = i_rw; m2r = i_m2r; mr = i_mr; mw = i_mw;
      ack = (ack_dly == 0);
      rdata = (ack_dly == 0) ? i_rdata : BAD;
      e.err = mop && (ack_dly > TIMEOUT);
      e.wd  = exp_wb;
      e.rd  = i_rd;
      e.rw  = e.err ? 1'b0 : i_rw;
      e.ins = e.err ? 32'h0 : i_ins;
      sb.push_back(e);
      c = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         stall_exp = mop && (c < ack_dly) && (c < TIMEOUT);
         chk("req", {31'h0, req}, {31'h0, mop});
         chk("stall", {31'h0, stall}, {31'h0, stall_exp});
         if (mop && c == 0) begin
            chk("we", {31'h0, we}, {31'h0, i_mw & ~i_mr});
            chk("addr", addr, {i_alu[31:2], 2'b00});
            chk("byteen", {28'h0, be}, {28'h0, exp_be});
            chk("wdata", wdata, exp_wd);
         end
         if (c >= 1) chk("wb_hold", wb_ins, last_ins);
         if (!stall_exp) begin
            done = 1'b1;
         end else begin
            @(posedge clk) #1;
            c++;
            ack = (c == ack_dly);
            rdata = (c == ack_dly) ? i_rdata : BAD;
         end
      end
      @(posedge clk) #1;
      ack = 1'b0;
      rdata = BAD;
      last_ins = e.ins;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      alu = 0; rt = 0; ins = 0; rd = 0; rw = 0; m2r = 0; mr = 0; mw = 0;
      ack = 0; rdata = BAD;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", {31'h0, req}, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_wb_wdata", wb_wd, 32'h0);
      chk("rst_wb_regw", {31'h0, wb_rw}, 32'h0);
      chk("rst_wb_instr", wb_ins, 32'h0);
      chk("rst_wb_err", {31'h0, wb_err}, 32'h0);
      @(posedge clk) #1;
      rst_n = 1'b1;

      // lw, same-cycle ack
      issue(32'h8C22_0100, 32'h100, 32'h0, 5'd2, 1, 1, 1, 0, 0, 32'hDEADBEEF,
            32'hDEADBEEF, 4'hF, 32'h0);
      // sw 0x104, ack after 3 cycles
      issue(32'hAC43_0104, 32'h104, 32'hCAFEF00D, 5'd0, 0, 0, 0, 1, 3, 32'h0,
            32'h104, 4'hF, 32'hCAFEF00D);
      // ALU op, stray ack ignored
      issue(32'h0022_1820, 32'h7, 32'h5, 5'd3, 1, 0, 0, 0, 0, 32'h0,
            32'h7, 4'hF, 32'h5);
      // lw with no ack -> timeout abort
      issue(32'h8C24_0040, 32'h40, 32'h0, 5'd4, 1, 1, 1, 0, 100, 32'h0,
            32'h0, 4'hF, 32'h0);
      // NOP: error pulse must be gone
      issue(32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1000, 32'h0,
            32'h0, 4'hF, 32'h0);
      // misaligned lw, ack after 2
      issue(32'h8C26_010B, 32'h10B, 32'h0, 5'd6, 1, 1, 1, 0, 2, 32'h12345678,
            32'h12345678, 4'hF, 32'h0);
      // read and write both set -> read
      issue(32'h8C27_0020, 32'h20, 32'h99, 5'd7, 1, 1, 1, 1, 1, 32'h000055AA,
            32'h000055AA, 4'hF, 32'h99);

      // reset during an outstanding access
      ins = 32'h8C25_0200; alu = 32'h200; rt = 0; rd = 5'd5;
      rw = 1; m2r = 1; mr = 1; mw = 0; ack = 0; rdata = BAD;
      repeat (3) begin
         @(negedge clk);
         chk("pre_rst_stall", {31'h0, stall}, 32'h1);
         @(posedge clk) #1;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_req", {31'h0, req}, 32'h0);
      chk("midrst_stall", {31'h0, stall}, 32'h0);
      chk("midrst_wb_wdata", wb_wd, 32'h0);
      chk("midrst_wb_regw", {31'h0, wb_rw}, 32'h0);
      chk("midrst_wb_instr", wb_ins, 32'h0);
      @(posedge clk) #1;
      rst_n = 1'b1;
      last_ins = 32'h0;
      issue(32'h8C28_0300, 32'h300, 32'h0, 5'd8, 1, 1, 1, 0, 1, 32'h0F0F0F0F,
            32'h0F0F0F0F, 4'hF, 32'h0);

`ifdef MEM_BYTE_LANES_EN
      // lb addr 3
      issue(32'h8029_0003, 32'h3, 32'h0, 5'd9, 1, 1, 1, 0, 0, 32'h80FF0000,
            32'hFFFFFF80, 4'hF, 32'h0);
      // lbu addr 2
      issue(32'h902A_0002, 32'h2, 32'h0, 5'd10, 1, 1, 1, 0, 1, 32'h80FF0000,
            32'h000000FF, 4'hF, 32'h0);
      // lh addr 2
      issue(32'h842B_0002, 32'h2, 32'h0, 5'd11, 1, 1, 1, 0, 0, 32'h80FF0000,
            32'hFFFF80FF, 4'hF, 32'h0);
      // lhu addr 0
      issue(32'h942C_0000, 32'h0, 32'h0, 5'd12, 1, 1, 1, 0, 0, 32'h12348001,
            32'h00008001, 4'hF, 32'h0);
      // sh addr 2
      issue(32'hA42D_0002, 32'h2, 32'h1234, 5'd0, 0, 0, 0, 1, 1, 32'h0,
            32'h2, 4'b1100, 32'h12341234);
      // sb addr 1
      issue(32'hA02E_0001, 32'h1, 32'hAB, 5'd0, 0, 0, 0, 1, 0, 32'h0,
            32'h1, 4'b0010, 32'hABABABAB);
`endif

      // trailing NOP
      issue(32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1000, 32'h0,
            32'h0, 4'hF, 32'h0);
      @(negedge clk);
      #1;
      chk("sb_drained", sb.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
